mem_stage_ctrl: RTL and testbench

Sequences the memory stage behind the EX/MEM pipeline register. It decodes the SPARC format-3 load/store held in that register and runs a req/ack handshake to data memory, splitting LDD/STD into two 32-bit beats. It drives the `mem_ready` stall that freezes the EX/MEM register until the access completes. It also aligns, extends and assembles load data for writeback.

---
 rtl/mem_stage_ctrl_if.sv | 34 +++
 rtl/mem_stage_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
//==== mem_stage_ctrl_if : EX/MEM-side and data-memory-side signals of the memory stage. Rev 1.0 ====
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [1:0]        op_in;
  logic [5:0]        op3_in;
  logic [63:0]       addr_in;
  logic [63:0]       wdata_in;
  logic              mem_ready;
  logic [63:0]       ld_data;
  logic              ld_valid;
  logic              misalign;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (
    input  op_in, op3_in, addr_in, wdata_in, dmem_ack, dmem_rdata,
    output mem_ready, ld_data, ld_valid, misalign,
           dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );

  modport slave (
    output op_in, op3_in, addr_in, wdata_in, dmem_ack, dmem_rdata,
    input  mem_ready, ld_data, ld_valid, misalign,
           dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
//==== mem_stage_ctrl : memory-stage sequencer for SPARC format-3 loads/stores (LDD/STD in two beats). Rev 1.0 ====
module mem_stage_ctrl #(
  parameter int ADDR_W = 32,
  parameter int BUS_W  = 32
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  mem_stage_ctrl_if.master  mem_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [BUS_W-1:0]  wdata_q;
  logic              we_q;
  logic [31:0]       hi_q;
  logic [63:0]       ld_data_q;
  logic              ld_flag_q;
  logic              mis_q;

  logic              w_supported, w_is_st, w_signed, w_misalign;
  logic [1:0]        w_size;
  logic [3:0]        w_be;
  logic [BUS_W-1:0]  w_wdata0;
  logic [BUS_W-1:0]  w_rdata;
  logic [7:0]        w_lane_b;
  logic [15:0]       w_lane_h;
  logic [31:0]       w_ld_ext;
  logic              w_ack;
  logic              w_req, w_ready, w_ld_valid, w_misalign_p;
  logic              w_unused;

  assign w_rdata  = mem_if.dmem_rdata;
  assign w_ack    = mem_if.dmem_ack;
  assign w_unused = ^mem_if.addr_in[63:ADDR_W];

  always_comb begin
    w_supported = 1'b0;
    w_is_st     = 1'b0;
    w_signed    = 1'b0;
    w_size      = SZ_W;
    if (mem_if.op_in == 2'b11) begin
      case (mem_if.op3_in)
        6'b000000: begin w_supported = 1'b1; w_size = SZ_W; end
        6'b000001: begin w_supported = 1'b1; w_size = SZ_B; end
        6'b000010: begin w_supported = 1'b1; w_size = SZ_H; end
        6'b000011: begin w_supported = 1'b1; w_size = SZ_D; end
        6'b001001: begin w_supported = 1'b1; w_size = SZ_B; w_signed = 1'b1; end
        6'b001010: begin w_supported = 1'b1; w_size = SZ_H; w_signed = 1'b1; end
        6'b000100: begin w_supported = 1'b1; w_size = SZ_W; w_is_st = 1'b1; end
        6'b000101: begin w_supported = 1'b1; w_size = SZ_B; w_is_st = 1'b1; end
        6'b000110: begin w_supported = 1'b1; w_size = SZ_H; w_is_st = 1'b1; end
        6'b000111: begin w_supported = 1'b1; w_size = SZ_D; w_is_st = 1'b1; end
        default: ;
      endcase
    end
  end

  // Alignment, byte lanes and replicated first-beat store data.
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata0   = mem_if.wdata_in[31:0];
    case (w_size)
      SZ_B: begin
        w_be     = 4'b1000 >> mem_if.addr_in[1:0];
        w_wdata0 = {4{mem_if.wdata_in[7:0]}};
      end
      SZ_H: begin
        w_misalign = mem_if.addr_in[0];
        w_be       = 4'b1100 >> mem_if.addr_in[1:0];
        w_wdata0   = {2{mem_if.wdata_in[15:0]}};
      end
      SZ_W: w_misalign = (mem_if.addr_in[1:0] != 2'b00);
      SZ_D: begin
        w_misalign = (mem_if.addr_in[2:0] != 3'b000);
        w_wdata0   = mem_if.wdata_in[63:32];
      end
      default: ;
    endcase
  end

  // Byte offset k lives at rdata[31-8k -: 8], hence the inverted offset as shift.
  assign w_lane_b = 8'(w_rdata >> {~mem_if.addr_in[1:0], 3'b000});
  assign w_lane_h = 16'(w_rdata >> {~mem_if.addr_in[1], 4'b0000});

  always_comb begin
    case (w_size)
      SZ_B:    w_ld_ext = {{24{w_signed & w_lane_b[7]}}, w_lane_b};
      SZ_H:    w_ld_ext = {{16{w_signed & w_lane_h[15]}}, w_lane_h};
      default: w_ld_ext = w_rdata;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (w_supported) state_d = w_misalign ? S_DONE : S_ACC0;
      S_ACC0: if (w_ack) state_d = (w_size == SZ_D) ? S_ACC1 : S_DONE;
      S_ACC1: if (w_ack) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_req        = 1'b0;
    w_ready      = 1'b0;
    w_ld_valid   = 1'b0;
    w_misalign_p = 1'b0;
    case (state_q)
      S_IDLE: w_ready = ~w_supported;
      S_ACC0, S_ACC1: w_req = 1'b1;
      S_DONE: begin
        w_ready      = 1'b1;
        w_ld_valid   = ld_flag_q;
        w_misalign_p = mis_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      hi_q      <= '0;
      ld_data_q <= '0;
      ld_flag_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_supported) begin
            if (w_misalign) begin
              mis_q <= 1'b1;
            end else begin
              addr_q  <= mem_if.addr_in[ADDR_W-1:0];
              be_q    <= w_be;
              wdata_q <= w_wdata0;
              we_q    <= w_is_st;
            end
          end
        end
        S_ACC0: begin
          if (w_ack) begin
            if (w_size == SZ_D) begin
              addr_q  <= addr_q + ADDR_W'(4);
              wdata_q <= mem_if.wdata_in[31:0];
              hi_q    <= w_rdata;
            end else if (!w_is_st) begin
              ld_data_q <= {32'h0, w_ld_ext};
              ld_flag_q <= 1'b1;
            end
          end
        end
        S_ACC1: begin
          if (w_ack && !w_is_st) begin
            ld_data_q <= {hi_q, w_rdata};
            ld_flag_q <= 1'b1;
          end
        end
        S_DONE: begin
          ld_flag_q <= 1'b0;
          mis_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_if.mem_ready  = w_ready;
  assign mem_if.dmem_req   = w_req;
  assign mem_if.dmem_we    = we_q;
  assign mem_if.dmem_addr  = addr_q;
  assign mem_if.dmem_be    = be_q;
  assign mem_if.dmem_wdata = wdata_q;
  assign mem_if.ld_data    = ld_data_q;
  assign mem_if.ld_valid   = w_ld_valid;
  assign mem_if.misalign   = w_misalign_p;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
//==== tb_mem_stage_ctrl : scoreboard bench for the memory-stage sequencer. Rev 1.0 ====
module tb_mem_stage_ctrl;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_stage_ctrl_if #(.ADDR_W(32)) bus ();

  mem_stage_ctrl #(.ADDR_W(32), .BUS_W(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .mem_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STD  = 6'b000111;

  logic [63:0] exp_ld_q[$];
  logic [63:0] obs_ld_q[$];

  int          obs_cycles, obs_ready_low, obs_req_cycles, obs_beats;
  int          obs_valid_cnt, obs_mis_cnt, obs_mis_cycle;
  bit          obs_done, obs_unstable, obs_req_gap;
  logic [31:0] obs_addr [2];
  logic [3:0]  obs_be   [2];
  logic [31:0] obs_wdata[2];
  logic        obs_we   [2];

  // Present one op on the EX/MEM side and play data memory: ack each beat after 'delay' wait cycles.
  task automatic do_access(input logic [5:0] op3, input logic [63:0] addr, input logic [63:0] wdata,
                           input int delay, input logic [31:0] rd0, input logic [31:0] rd1);
    int wait_n = 0;
    int beat   = 0;
    bit done   = 0;
    obs_cycles = 0; obs_ready_low = 0; obs_req_cycles = 0; obs_valid_cnt = 0;
    obs_mis_cnt = 0; obs_mis_cycle = 0; obs_unstable = 0; obs_req_gap = 0;
    for (int b = 0; b < 2; b++) begin
      obs_addr[b] = 'x; obs_be[b] = 'x; obs_wdata[b] = 'x; obs_we[b] = 1'bx;
    end
    bus.op_in = 2'b11; bus.op3_in = op3; bus.addr_in = addr; bus.wdata_in = wdata; bus.dmem_ack = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      obs_cycles++;
      if (bus.ld_valid) begin obs_valid_cnt++; obs_ld_q.push_back(bus.ld_data); end
      if (bus.misalign) begin obs_mis_cnt++; obs_mis_cycle = obs_cycles; end
      if (bus.dmem_req && beat < 2) begin
        obs_req_cycles++;
        if (wait_n == 0) begin
          obs_addr[beat] = bus.dmem_addr; obs_be[beat] = bus.dmem_be;
          obs_wdata[beat] = bus.dmem_wdata; obs_we[beat] = bus.dmem_we;
        end else if (bus.dmem_addr !== obs_addr[beat] || bus.dmem_be !== obs_be[beat] ||
                     bus.dmem_wdata !== obs_wdata[beat] || bus.dmem_we !== obs_we[beat]) begin
          obs_unstable = 1;
        end
        if (wait_n == delay) begin
          bus.dmem_ack = 1'b1; bus.dmem_rdata = (beat == 0) ? rd0 : rd1; beat++; wait_n = 0;
        end else begin
          bus.dmem_ack = 1'b0; wait_n++;
        end
      end else begin
        if (bus.dmem_req) obs_req_cycles++;
        bus.dmem_ack = 1'b0;
        if (obs_req_cycles > 0 && !bus.mem_ready) obs_req_gap = 1;
      end
      if (bus.mem_ready) done = 1; else obs_ready_low++;
    end
    obs_done  = done;
    obs_beats = beat;
    @(posedge clk); #1;
    bus.op_in = 2'b10; bus.dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.dmem_req); end
    checks++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", bus.dmem_we); end
    checks++; if (bus.dmem_addr !== 32'h0 || bus.dmem_be !== 4'h0 || bus.dmem_wdata !== 32'h0)
      begin errors++; $display("FAIL rst_bus got addr %h be %b wdata %h exp all 0", bus.dmem_addr, bus.dmem_be, bus.dmem_wdata); end
    checks++; if (bus.ld_data !== 64'h0 || bus.ld_valid !== 1'b0 || bus.misalign !== 1'b0)
      begin errors++; $display("FAIL rst_ld got data %h valid %b mis %b exp 0", bus.ld_data, bus.ld_valid, bus.misalign); end
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.mem_ready); end
  endtask

  task automatic test_nonmem();
    bus.op_in = 2'b10; bus.op3_in = OP_LD; bus.addr_in = 64'h1000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.mem_ready !== 1'b1 || bus.dmem_req !== 1'b0)
        begin errors++; $display("FAIL nonmem_cycle%0d got ready %b req %b exp 1/0", i, bus.mem_ready, bus.dmem_req); end
    end
    bus.op_in = 2'b11; bus.op3_in = 6'b111111;
    @(negedge clk);
    checks++; if (bus.mem_ready !== 1'b1 || bus.dmem_req !== 1'b0)
      begin errors++; $display("FAIL nonmem_op3 got ready %b req %b exp 1/0", bus.mem_ready, bus.dmem_req); end
    @(posedge clk); #1 bus.op_in = 2'b10;
  endtask

  task automatic test_ldub();
    logic [63:0] got, exp;
    exp_ld_q.push_back(64'h00000000_000000BB);
    do_access(OP_LDUB, 64'h1001, 64'h0, 0, 32'hAABBCCDD, 32'h0);
    checks++; if (!obs_done || obs_cycles != 3) begin errors++; $display("FAIL ldub_cycles got %0d exp 3", obs_cycles); end
    checks++; if (obs_req_cycles != 1) begin errors++; $display("FAIL ldub_req got %0d exp 1", obs_req_cycles); end
    checks++; if (obs_addr[0] !== 32'h1001 || obs_be[0] !== 4'b0100 || obs_we[0] !== 1'b0)
      begin errors++; $display("FAIL ldub_beat got addr %h be %b we %b exp 1001/0100/0", obs_addr[0], obs_be[0], obs_we[0]); end
    checks++;
    if (obs_valid_cnt != 1 || obs_ld_q.size() == 0) begin
      errors++; $display("FAIL ldub_valid got %0d pulses exp 1", obs_valid_cnt);
      void'(exp_ld_q.pop_front());
    end else begin
      got = obs_ld_q.pop_front(); exp = exp_ld_q.pop_front();
      if (got !== exp) begin errors++; $display("FAIL ldub_data got %h exp %h", got, exp); end
    end
  endtask

  task automatic test_ldsh_wait();
    logic [63:0] got, exp;
    exp_ld_q.push_back(64'h00000000_FFFFF00D);
    do_access(OP_LDSH, 64'h1002, 64'h0, 2, 32'h1234F00D, 32'h0);
    checks++; if (obs_req_cycles != 3 || obs_unstable) begin errors++; $display("FAIL ldsh_req got %0d cycles unstable %b exp 3/0", obs_req_cycles, obs_unstable); end
    checks++; if (obs_be[0] !== 4'b0011 || obs_addr[0] !== 32'h1002) begin errors++; $display("FAIL ldsh_be got %b addr %h exp 0011/1002", obs_be[0], obs_addr[0]); end
    checks++; if (!obs_done || obs_ready_low != 4) begin errors++; $display("FAIL ldsh_stall got %0d exp 4", obs_ready_low); end
    checks++;
    if (obs_ld_q.size() == 0) begin
      errors++; $display("FAIL ldsh_valid got 0 pulses exp 1"); void'(exp_ld_q.pop_front());
    end else begin
      got = obs_ld_q.pop_front(); exp = exp_ld_q.pop_front();
      if (got !== exp) begin errors++; $display("FAIL ldsh_data got %h exp %h", got, exp); end
    end
  endtask

  task automatic test_double();
    logic [63:0] got, exp;
    exp_ld_q.push_back(64'h11111111_22222222);
    do_access(OP_LDD, 64'h2000, 64'h0, 1, 32'h11111111, 32'h22222222);
    checks++; if (obs_beats != 2 || obs_addr[0] !== 32'h2000 || obs_addr[1] !== 32'h2004)
      begin errors++; $display("FAIL ldd_addr got %0d beats %h %h exp 2000 2004", obs_beats, obs_addr[0], obs_addr[1]); end
    checks++; if (obs_req_cycles != 4 || obs_req_gap || obs_unstable || obs_be[1] !== 4'b1111)
      begin errors++; $display("FAIL ldd_req got %0d cycles gap %b unstable %b be %b exp 4/0/0/1111", obs_req_cycles, obs_req_gap, obs_unstable, obs_be[1]); end
    checks++;
    if (obs_ld_q.size() == 0) begin
      errors++; $display("FAIL ldd_valid got 0 pulses exp 1"); void'(exp_ld_q.pop_front());
    end else begin
      got = obs_ld_q.pop_front(); exp = exp_ld_q.pop_front();
      if (got !== exp) begin errors++; $display("FAIL ldd_data got %h exp %h", got, exp); end
    end
    do_access(OP_STD, 64'h2008, 64'hCAFEBABE_DEADBEEF, 0, 32'h0, 32'h0);
    checks++; if (obs_wdata[0] !== 32'hCAFEBABE || obs_wdata[1] !== 32'hDEADBEEF)
      begin errors++; $display("FAIL std_wdata got %h %h exp CAFEBABE DEADBEEF", obs_wdata[0], obs_wdata[1]); end
    checks++; if (obs_we[0] !== 1'b1 || obs_we[1] !== 1'b1 || obs_addr[1] !== 32'h200C || obs_valid_cnt != 0)
      begin errors++; $display("FAIL std_ctl got we %b%b addr1 %h valid %0d exp 11/200C/0", obs_we[0], obs_we[1], obs_addr[1], obs_valid_cnt); end
  endtask

  task automatic test_stb_misalign();
    do_access(OP_STB, 64'h3003, 64'h5A, 0, 32'h0, 32'h0);
    checks++; if (obs_be[0] !== 4'b0001 || obs_wdata[0] !== 32'h5A5A5A5A || obs_we[0] !== 1'b1)
      begin errors++; $display("FAIL stb_beat got be %b wdata %h we %b exp 0001/5A5A5A5A/1", obs_be[0], obs_wdata[0], obs_we[0]); end
    checks++; if (obs_valid_cnt != 0 || bus.ld_data !== 64'h11111111_22222222)
      begin errors++; $display("FAIL stb_ld got %0d pulses data %h exp 0/1111111122222222", obs_valid_cnt, bus.ld_data); end
    do_access(OP_LD, 64'h4002, 64'h0, 0, 32'h0, 32'h0);
    checks++; if (obs_req_cycles != 0) begin errors++; $display("FAIL mis_req got %0d exp 0", obs_req_cycles); end
    checks++; if (!obs_done || obs_cycles != 2 || obs_mis_cnt != 1 || obs_mis_cycle != 2 || obs_valid_cnt != 0)
      begin errors++; $display("FAIL mis_pulse got cycles %0d pulses %0d at %0d valid %0d exp 2/1/2/0", obs_cycles, obs_mis_cnt, obs_mis_cycle, obs_valid_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got, exp;
    exp_ld_q.push_back(64'h00000000_FFFFFF80);
    do_access(OP_LDSB, 64'h5003, 64'h0, 0, 32'h00000080, 32'h0);
    exp_ld_q.push_back(64'h00000000_89ABCDEF);
    do_access(OP_LD, 64'h6004, 64'h0, 1, 32'h89ABCDEF, 32'h0);
    exp_ld_q.push_back(64'h00000000_00008001);
    do_access(OP_LDUH, 64'h6002, 64'h0, 0, 32'hDEAD8001, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      exp = exp_ld_q.pop_front();
      if (obs_ld_q.size() == 0) begin errors++; $display("FAIL b2b_%0d got no result exp %h", i, exp); end
      else begin
        got = obs_ld_q.pop_front();
        if (got !== exp) begin errors++; $display("FAIL b2b_%0d got %h exp %h", i, got, exp); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit in_acc1 = 0;
    bus.op_in = 2'b11; bus.op3_in = OP_LDD; bus.addr_in = 64'h2000; bus.dmem_ack = 1'b0;
    for (int c = 0; c < 20 && !in_acc1; c++) begin
      @(negedge clk);
      if (bus.dmem_req && bus.dmem_addr === 32'h2004) begin in_acc1 = 1; bus.dmem_ack = 1'b0; end
      else if (bus.dmem_req) begin bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h11111111; end
      else bus.dmem_ack = 1'b0;
    end
    checks++; if (!in_acc1) begin errors++; $display("FAIL rmid_acc1 got 0 exp 1"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rmid_req got %b exp 0", bus.dmem_req); end
    checks++; if (bus.dmem_addr !== 32'h0 || bus.dmem_be !== 4'h0 || bus.dmem_wdata !== 32'h0 || bus.dmem_we !== 1'b0 ||
                 bus.ld_data !== 64'h0 || bus.ld_valid !== 1'b0 || bus.misalign !== 1'b0)
      begin errors++; $display("FAIL rmid_outs got addr %h be %b wd %h ld %h exp 0", bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, bus.ld_data); end
    bus.op_in = 2'b10;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h22222222;
    @(negedge clk);
    checks++; if (bus.dmem_req !== 1'b0 || bus.ld_valid !== 1'b0 || bus.mem_ready !== 1'b1 || bus.ld_data !== 64'h0)
      begin errors++; $display("FAIL rmid_ack got req %b valid %b ready %b ld %h exp 0/0/1/0", bus.dmem_req, bus.ld_valid, bus.mem_ready, bus.ld_data); end
    bus.dmem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.op_in = 2'b00; bus.op3_in = 6'h0; bus.addr_in = 64'h0; bus.wdata_in = 64'h0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    test_reset();
    @(posedge clk); #1 rst = 1'b0;
    test_nonmem();
    test_ldub();
    test_ldsh_wait();
    test_double();
    test_stb_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "bench timed out");
  end

endmodule
`default_nettype wire
